// File: rtl/hififo_tpc_fifo.sv
// -----------------------------------------------------------------------------
// hififo_tpc_fifo
//
// Card-to-host (to-PC) buffer for one DMA channel. User logic pushes 64-bit
// words into a 512-word block RAM. The RAM is treated as eight 64-word
// (512-byte) blocks. Each completely filled block produces one write request
// towards the PCIe TX engine. Once the request is accepted, a 64-word data
// burst follows, and the engine turns it into one memory-write TLP.
// A partially filled block is never requested.
//
// Ports
//   clock            single clock for every port
//   reset            synchronous, active-high
//   channel[2:0]     static channel number, echoed on request_tag[5:3]
//   fifo_write       push fifo_write_data this cycle
//   fifo_write_data  64-bit data word
//   fifo_ready       space for at least one word (low while reset is high)
//   overflow         sticky: a push was attempted while fifo_ready was low
//   request_valid    one full block is waiting to be sent
//   request_ready    TX engine accepts the request
//   request_tag[5:0] {channel, block index}; held while request_valid is high
//   data_valid       data_out holds a word of the accepted block
//   data_ready       TX engine consumes data_out
//   data_out[63:0]   burst word
//   data_last        word 63 of the burst
// -----------------------------------------------------------------------------
module hififo_tpc_fifo (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  channel,
  input  logic        fifo_write,
  input  logic [63:0] fifo_write_data,
  output logic        fifo_ready,
  output logic        overflow,
  output logic        request_valid,
  input  logic        request_ready,
  output logic [5:0]  request_tag,
  output logic        data_valid,
  input  logic        data_ready,
  output logic [63:0] data_out,
  output logic        data_last
);

  typedef enum logic [1:0] {
    S_IDLE,    // waiting for a full, unrequested block
    S_REQ,     // request_valid high until the TX engine accepts it
    S_PRIME,   // one cycle for the block RAM to deliver the first word
    S_STREAM   // burst of 64 words, flow-controlled by data_ready
  } state_t;

  // ---------------------------------------------------------------------------
  // Pointers and storage
  // ---------------------------------------------------------------------------
  // wp and rp carry one wrap bit above the 9 address bits. Because of the wrap
  // bit, "empty" (difference 0) and "full" (difference 512) are distinct, and
  // modulo-1024 subtraction needs no special case at the wrap.
  logic [9:0]  wp;
  logic [9:0]  rp;
  logic [3:0]  rb;          // block pointer: next block to request
  logic [5:0]  word_cnt;    // word index within the current burst
  state_t      state;
  state_t      state_next;

  logic [63:0] ram [0:511];
  logic [63:0] ram_q;       // registered read port; drives data_out directly

  logic [9:0]  occupancy;
  logic        full;
  logic        push;
  logic        pop;
  logic        req_accept;
  logic [3:0]  full_blocks;
  logic        block_pending;
  logic [8:0]  rd_addr;

  assign occupancy = wp - rp;
  assign full      = (occupancy == 10'd512);

  // fifo_ready is built from the registered pointers and the reset input only,
  // so a pop in cycle P shows up as free space in cycle P+1.
  assign fifo_ready = !reset && !full;

  assign push       = fifo_write && fifo_ready;
  assign pop        = (state == S_STREAM) && data_ready;
  assign req_accept = (state == S_REQ) && request_ready;

  // Completed blocks that have not been requested yet. The 4-bit difference
  // covers 0..8, and it wraps cleanly after block 7 because both operands are
  // free-running modulo 16.
  assign full_blocks   = wp[9:6] - rb;
  assign block_pending = (full_blocks != 4'd0);

  // Read-address lookahead. The read port always fetches the word that will
  // sit at the head of the burst in the next cycle. On a pop it fetches rp+1,
  // and data streams at one word per cycle. On a stall it re-reads rp, so
  // data_out holds its value. The slot at rp+1 inside an accepted block is
  // always already written, and it cannot be overwritten until it is popped.
  // As a result no separate skid register is needed.
  assign rd_addr = pop ? (rp[8:0] + 9'd1) : rp[8:0];

  // NOTE: the storage array has no reset. Its contents are meaningless until
  // they are written, and adding a reset would stop the array from mapping
  // onto block RAM.
  always_ff @(posedge clock) begin : ram_port
    if (push) begin
      ram[wp[8:0]] <= fifo_write_data;
    end
    ram_q <= ram[rd_addr];
  end

  // NOTE: every register below uses non-blocking assignments. All state then
  // updates together at the clock edge, and no block depends on the order in
  // which the others are evaluated.
  always_ff @(posedge clock) begin : control_regs
    if (reset) begin
      wp       <= '0;
      rp       <= '0;
      rb       <= '0;
      word_cnt <= '0;
      overflow <= 1'b0;
      state    <= S_IDLE;
    end else begin
      state <= state_next;

      if (push) begin
        wp <= wp + 10'd1;
      end

      // Space is released one word at a time as the TX engine consumes it.
      // It is not released when the burst completes.
      if (pop) begin
        rp       <= rp + 10'd1;
        word_cnt <= word_cnt + 6'd1;
      end

      if (req_accept) begin
        rb <= rb + 4'd1;
      end

      // A dropped word is remembered until the next reset.
      if (fifo_write && !fifo_ready) begin
        overflow <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Request / burst sequencing
  // ---------------------------------------------------------------------------
  // The FSM returns to IDLE only after data_last has been consumed, so at most
  // one burst is in flight. IDLE reads block_pending, which comes from the
  // registered wp. A block completed in cycle N is therefore seen in N+1 and
  // requested in N+2.
  // NOTE: every output of this block gets a default first. A path that does
  // not assign a variable then keeps the default, and no latch is inferred.
  always_comb begin : fsm_next
    state_next    = state;
    request_valid = 1'b0;
    data_valid    = 1'b0;
    data_last     = 1'b0;

    case (state)
      S_IDLE: begin
        if (block_pending) begin
          state_next = S_REQ;
        end
      end

      S_REQ: begin
        request_valid = 1'b1;
        if (request_ready) begin
          state_next = S_PRIME;
        end
      end

      S_PRIME: begin
        state_next = S_STREAM;
      end

      S_STREAM: begin
        data_valid = 1'b1;
        data_last  = (word_cnt == 6'd63);
        if (data_ready && (word_cnt == 6'd63)) begin
          state_next = S_IDLE;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // rb advances only on acceptance, so the tag cannot change while the request
  // is pending.
  assign request_tag = {channel, rb[2:0]};
  assign data_out    = ram_q;

endmodule

// File: doc/hififo_tpc_fifo.md
# hififo_tpc_fifo

To-PC (card-to-host) buffer for one DMA channel. User logic pushes 64-bit words into a 512-word block RAM organised as eight 64-word (512-byte) blocks. Each completely filled block produces one write request to the PCIe TX engine, followed by a 64-word data burst that the engine turns into a memory-write TLP. It is the transmit counterpart of the from-PC completion FIFO and sits between user logic and the TX TLP builder.

## Interface
Parameters
- none; block size is fixed at 64 words and depth at 8 blocks.

Ports
- clock  in  1  single clock for every port.
- reset  in  1  synchronous, active-high.
- channel  in  3  static channel number; echoed on request_tag[5:3].
- fifo_write  in  1  push fifo_write_data this cycle.
- fifo_write_data  in  64  data word.
- fifo_ready  out  1  space for at least one word.
- overflow  out  1  sticky: a push was attempted while fifo_ready=0.
- request_valid  out  1  one full block is ready to send.
- request_ready  in  1  TX engine accepts the request.
- request_tag  out  6  {channel, block index[2:0]}; stable while request_valid=1.
- data_valid  out  1  data_out holds a word of the accepted block.
- data_ready  in  1  TX engine consumes data_out.
- data_out  out  64  burst word.
- data_last  out  1  word 63 of the burst.

## Operation
- Pointers: wp and rp are 10 bits (9 address bits plus 1 wrap bit).
  - Occupancy = wp - rp, modulo 1024, range 0..512.
  - fifo_ready = !reset && (occupancy != 512).
- Push: when fifo_write && fifo_ready, write RAM[wp[8:0]] and increment wp.
  - When fifo_write && !fifo_ready, the word is dropped, wp is unchanged and overflow is set.
  - overflow clears only on reset.
- Full blocks are counted as wp[9:6] - rb, where rb is a 4-bit block pointer that advances when a request is accepted. Partial blocks are never requested.
- rp increments on each accepted data word (data_valid && data_ready). Space is freed word by word.
- State machine:
  - IDLE: if at least one full block is unrequested, go to REQ.
  - REQ: request_valid=1 and request_tag={channel, rb[2:0]}. On request_ready, increment rb and go to PRIME.
  - PRIME: one cycle for the BRAM read of the first word. Go to STREAM.
  - STREAM: data_valid=1. Each accepted word advances rp and a 6-bit word counter. data_last=1 when the counter is 63. When the last word is accepted, go to IDLE.
- The output path must keep the word stable and valid while data_ready=0, and must sustain one word per cycle while data_ready=1. This needs a registered output plus a skid or prefetch.
- Only one burst is in flight at a time. The next request is never raised before the current burst's data_last is accepted.
- A push and a pop in the same cycle are both honoured, and occupancy is unchanged.
- Wrap-around: block index 7 is followed by block 0. Pointer arithmetic is modulo 1024, and no special case is allowed at the wrap.

## Timing
- Reset (synchronous), effective the cycle after reset is sampled:
  - wp, rp, rb, word counter = 0; state = IDLE.
  - request_valid, data_valid, data_last, overflow = 0.
  - fifo_ready = 0 while reset is high and 1 on the first cycle after.
  - data_out is don't-care.
- Reset mid-burst or mid-request abandons all buffered data; the TX engine must discard any partial TLP.
- The 64th word of a block is pushed in cycle N:
  - If IDLE, request_valid=1 in cycle N+2 (one cycle to register the count, one for the state).
  - Otherwise, request_valid=1 two cycles after the current burst completes.
- Request accepted in cycle A: first data_valid=1 in cycle A+2.
- Burst with data_ready held high: 64 consecutive cycles, with data_last in cycle A+65.
- request_valid is held until accepted and must not drop or change tag before then.
- fifo_ready is combinational from registered pointers. A word popped in cycle P frees space that is visible in cycle P+1.

## Test plan
- Reset, then push 64 words 0..63 with request_ready=1 and data_ready=1:
  - one request with tag {channel, 0};
  - data_out 0..63 on consecutive cycles;
  - data_last on the word 63;
  - request_valid=0 afterwards.
- Push 63 words only: no request ever asserts. Push the 64th word: request_valid=1 two cycles later.
- Push 512 words with request_ready=0: fifo_ready goes to 0 after word 512. A 513th push sets overflow and the stored data is unchanged. Then release request_ready: eight requests with tags 0..7 and data in order.
- Random data_ready toggling over 20 blocks while pushes run concurrently: no word lost, duplicated or reordered; tag wraps 7 to 0; data_out is stable while data_valid && !data_ready.
- Assert reset on word 30 of a burst: the next cycle has request_valid=0, data_valid=0, overflow=0 and fifo_ready=0, then fifo_ready=1. A fresh 64-word push produces tag {channel, 0}.
